// File: rtl/ysyx_25040129_bus_pkg.sv
// Shared bus constants for the IFU/LSU -> MMU arbiter.
//   ST_*            arbiter state encoding (legacy-compatible 2-bit codes)
//   AXI_SIZE_WORD   32-bit transfer size used for IFU fetches
//   AXI_BURST_INCR  burst type driven on every read (single beat)
//   AXI_LEN_SINGLE  arlen value for a single-beat burst
//   RESP_OKAY       response code idled onto response outputs that carry no beat
package ysyx_25040129_bus_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_IFU = 2'd1;
  localparam logic [1:0] ST_RD_LSU = 2'd2;
  localparam logic [1:0] ST_WR_LSU = 2'd3;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage

// File: rtl/ysyx_25040129_arb_pick.sv
// Combinational winner select for the MMU arbiter.
// The returned code is the state the arbiter moves to on a grant (ST_IDLE = no request).
// An LSU write (awvalid && wvalid together) always wins over both reads.
// Optional macro ARB_RR_EN: the two reads alternate through a last-grant
// register (reset value = LSU, so the IFU goes first); otherwise the LSU read
// beats the IFU read.
// Ports:
//   clk, rst   clock / synchronous active-high reset (ARB_RR_EN only)
//   en_i       a grant is taken this cycle (ARB_RR_EN only)
//   ifu_rd_i   IFU read request
//   lsu_rd_i   LSU read request
//   lsu_wr_i   LSU write request (address and data both valid)
//   pick_o     winning grant state
module ysyx_25040129_arb_pick
  import ysyx_25040129_bus_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
`endif
  input  logic       ifu_rd_i,
  input  logic       lsu_rd_i,
  input  logic       lsu_wr_i,
  output logic [1:0] pick_o
);

  logic lsu_first;

`ifdef ARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  always_comb begin
    last_lsu_d = last_lsu_q;
    // Only read grants move the round-robin pointer.
    if (en_i && !lsu_wr_i && (pick_o != ST_IDLE))
      last_lsu_d = (pick_o == ST_RD_LSU);
  end

  always_ff @(posedge clk) begin
    if (rst) last_lsu_q <= 1'b1;
    else     last_lsu_q <= last_lsu_d;
  end

  // The LSU yields only when the IFU also wants the bus and the LSU went last.
  assign lsu_first = !(ifu_rd_i && last_lsu_q);
`else
  assign lsu_first = 1'b1;
`endif

  always_comb begin
    pick_o = ST_IDLE;
    if (lsu_wr_i)                   pick_o = ST_WR_LSU;
    else if (lsu_rd_i && lsu_first) pick_o = ST_RD_LSU;
    else if (ifu_rd_i)              pick_o = ST_RD_IFU;
  end

endmodule

// File: rtl/ysyx_25040129_mem_arbiter.sv
// 2:1 arbiter in front of the MMU: merges IFU reads and LSU reads/writes onto
// the MMU's single in_* port. One outstanding single-beat transaction at a time.
// The granted payload (addr, size, wdata, wstrb, satp) is registered at grant and
// held until the response completes, because the MMU re-reads the address
// throughout its page walk.
// Optional macro ARB_RR_EN: round-robin between the two reads (see arb_pick).
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   satp              satp CSR, latched at grant
//   ifu_ar*/ifu_r*    IFU read request / response
//   lsu_ar*/lsu_r*    LSU read request / response
//   lsu_aw*/lsu_w*    LSU write address / data (accepted together)
//   lsu_b*            LSU write response
//   mmu_*             single upstream port into the MMU
module ysyx_25040129_mem_arbiter
  import ysyx_25040129_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           satp,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic [2:0]            lsu_arsize,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_awready,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  output logic [ADDR_W-1:0]     mmu_araddr,
  output logic [2:0]            mmu_arsize,
  output logic [7:0]            mmu_arlen,
  output logic [1:0]            mmu_arburst,
  output logic [31:0]           mmu_arsatp,
  output logic                  mmu_arvalid,
  input  logic                  mmu_arready,
  input  logic [DATA_W-1:0]     mmu_rdata,
  input  logic [1:0]            mmu_rresp,
  input  logic                  mmu_rvalid,
  input  logic                  mmu_rlast,
  output logic                  mmu_rready,
  output logic [ADDR_W-1:0]     mmu_awaddr,
  output logic [31:0]           mmu_awsatp,
  output logic                  mmu_awvalid,
  input  logic                  mmu_awready,
  output logic [DATA_W-1:0]     mmu_wdata,
  output logic [DATA_W/8-1:0]   mmu_wstrb,
  output logic                  mmu_wvalid,
  input  logic                  mmu_wready,
  input  logic [1:0]            mmu_bresp,
  input  logic                  mmu_bvalid,
  output logic                  mmu_bready
);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [31:0]         satp_q, satp_d;
  logic                ar_sent_q, ar_sent_d;
  logic                aw_sent_q, aw_sent_d;
  logic                w_sent_q, w_sent_d;

  logic       grant_en, wr_req, rd_ifu, rd_lsu, wr;
  logic [1:0] pick, grant;

  assign wr_req   = lsu_awvalid && lsu_wvalid;
  // No grant is taken while reset is held.
  assign grant_en = (state_q == ST_IDLE) && !rst;
  assign grant    = grant_en ? pick : ST_IDLE;

  ysyx_25040129_arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk      (clk),
    .rst      (rst),
    .en_i     (grant_en),
`endif
    .ifu_rd_i (ifu_arvalid),
    .lsu_rd_i (lsu_arvalid),
    .lsu_wr_i (wr_req),
    .pick_o   (pick)
  );

  assign rd_ifu = (state_q == ST_RD_IFU);
  assign rd_lsu = (state_q == ST_RD_LSU);
  assign wr     = (state_q == ST_WR_LSU);

  assign ifu_arready = (grant == ST_RD_IFU);
  assign lsu_arready = (grant == ST_RD_LSU);
  assign lsu_awready = (grant == ST_WR_LSU);
  assign lsu_wready  = (grant == ST_WR_LSU);

  assign mmu_araddr  = addr_q;
  assign mmu_arsize  = size_q;
  assign mmu_arlen   = AXI_LEN_SINGLE;
  assign mmu_arburst = AXI_BURST_INCR;
  assign mmu_arsatp  = satp_q;
  assign mmu_arvalid = (rd_ifu || rd_lsu) && !ar_sent_q;
  assign mmu_rready  = (rd_ifu && ifu_rready) || (rd_lsu && lsu_rready);

  assign ifu_rdata  = mmu_rdata;
  assign ifu_rresp  = rd_ifu ? mmu_rresp : RESP_OKAY;
  assign ifu_rvalid = rd_ifu && mmu_rvalid;
  assign lsu_rdata  = mmu_rdata;
  assign lsu_rresp  = rd_lsu ? mmu_rresp : RESP_OKAY;
  assign lsu_rvalid = rd_lsu && mmu_rvalid;

  assign mmu_awaddr  = addr_q;
  assign mmu_awsatp  = satp_q;
  assign mmu_awvalid = wr && !aw_sent_q;
  assign mmu_wdata   = wdata_q;
  assign mmu_wstrb   = wstrb_q;
  assign mmu_wvalid  = wr && !w_sent_q;
  assign mmu_bready  = wr && lsu_bready;
  assign lsu_bvalid  = wr && mmu_bvalid;
  assign lsu_bresp   = wr ? mmu_bresp : RESP_OKAY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    satp_d    = satp_q;
    ar_sent_d = ar_sent_q;
    aw_sent_d = aw_sent_q;
    w_sent_d  = w_sent_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != ST_IDLE) begin
          state_d   = grant;
          satp_d    = satp;
          ar_sent_d = 1'b0;
          aw_sent_d = 1'b0;
          w_sent_d  = 1'b0;
          case (grant)
            ST_WR_LSU: begin
              addr_d  = lsu_awaddr;
              size_d  = AXI_SIZE_WORD;
              wdata_d = lsu_wdata;
              wstrb_d = lsu_wstrb;
            end
            ST_RD_LSU: begin
              addr_d = lsu_araddr;
              size_d = lsu_arsize;
            end
            default: begin
              addr_d = ifu_araddr;
              size_d = AXI_SIZE_WORD;
            end
          endcase
        end
      end
      ST_RD_IFU, ST_RD_LSU: begin
        if (mmu_arvalid && mmu_arready) ar_sent_d = 1'b1;
        // The response may land in the same cycle as the address handshake.
        if (mmu_rvalid && mmu_rready && mmu_rlast) state_d = ST_IDLE;
      end
      default: begin
        if (mmu_awvalid && mmu_awready) aw_sent_d = 1'b1;
        if (mmu_wvalid && mmu_wready)   w_sent_d  = 1'b1;
        if (mmu_bvalid && mmu_bready)   state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      satp_q    <= '0;
      ar_sent_q <= 1'b0;
      aw_sent_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      satp_q    <= satp_d;
      ar_sent_q <= ar_sent_d;
      aw_sent_q <= aw_sent_d;
      w_sent_q  <= w_sent_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed bench for ysyx_25040129_mem_arbiter with a response scoreboard.
// Expected responses (master, data, resp) are queued when a request is driven
// and popped when the arbiter presents a response to a master.
module tb_ysyx_25040129_mem_arbiter;

  localparam logic [1:0] K_IFU = 2'd0;
  localparam logic [1:0] K_LSU = 2'd1;
  localparam logic [1:0] K_WR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] satp;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_awready, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] mmu_araddr;
  logic [2:0]  mmu_arsize;
  logic [7:0]  mmu_arlen;
  logic [1:0]  mmu_arburst;
  logic [31:0] mmu_arsatp;
  logic        mmu_arvalid, mmu_arready;
  logic [31:0] mmu_rdata;
  logic [1:0]  mmu_rresp;
  logic        mmu_rvalid, mmu_rlast, mmu_rready;
  logic [31:0] mmu_awaddr, mmu_awsatp;
  logic        mmu_awvalid, mmu_awready;
  logic [31:0] mmu_wdata;
  logic [3:0]  mmu_wstrb;
  logic        mmu_wvalid, mmu_wready;
  logic [1:0]  mmu_bresp;
  logic        mmu_bvalid, mmu_bready;

  always #5 clk = ~clk;

  ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .satp(satp),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_awready(lsu_awready), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .mmu_araddr(mmu_araddr), .mmu_arsize(mmu_arsize), .mmu_arlen(mmu_arlen), .mmu_arburst(mmu_arburst),
    .mmu_arsatp(mmu_arsatp), .mmu_arvalid(mmu_arvalid), .mmu_arready(mmu_arready),
    .mmu_rdata(mmu_rdata), .mmu_rresp(mmu_rresp), .mmu_rvalid(mmu_rvalid), .mmu_rlast(mmu_rlast),
    .mmu_rready(mmu_rready),
    .mmu_awaddr(mmu_awaddr), .mmu_awsatp(mmu_awsatp), .mmu_awvalid(mmu_awvalid), .mmu_awready(mmu_awready),
    .mmu_wdata(mmu_wdata), .mmu_wstrb(mmu_wstrb), .mmu_wvalid(mmu_wvalid), .mmu_wready(mmu_wready),
    .mmu_bresp(mmu_bresp), .mmu_bvalid(mmu_bvalid), .mmu_bready(mmu_bready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.resp = r;
    exp_q.push_back(e);
  endtask

  task automatic observe_r;
    exp_t e;
    chk("sb_has_read", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("r_ifu_valid", ifu_rvalid, (e.kind == K_IFU) ? 32'd1 : 32'd0);
      chk("r_lsu_valid", lsu_rvalid, (e.kind == K_LSU) ? 32'd1 : 32'd0);
      chk("r_data", (e.kind == K_IFU) ? ifu_rdata : lsu_rdata, e.data);
      chk("r_resp", (e.kind == K_IFU) ? ifu_rresp : lsu_rresp, e.resp);
    end
  endtask

  task automatic observe_b;
    exp_t e;
    chk("sb_has_write", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("b_kind", e.kind, K_WR);
      chk("b_valid", lsu_bvalid, 1);
      chk("b_resp", lsu_bresp, e.resp);
      chk("b_no_rvalid", ifu_rvalid | lsu_rvalid, 0);
    end
  endtask

  // Entered while settled in the grant cycle; leaves settled in the next IDLE cycle.
  task automatic run_read(input logic [31:0] ea, input logic [2:0] esz, input int ar_at,
                          input int r_at, input logic [31:0] rd, input logic [1:0] rr,
                          input logic drop_i, input logic drop_l);
    logic [31:0] s;
    s = satp;
    tick;
    satp = s ^ 32'h5A5A_0000;
    if (drop_i) begin ifu_arvalid = 1'b0; ifu_araddr = '1; end
    if (drop_l) begin lsu_arvalid = 1'b0; lsu_araddr = '1; end
    for (int i = 0; i <= r_at; i++) begin
      mmu_arready = (i == ar_at);
      mmu_rvalid  = (i == r_at);
      mmu_rlast   = (i == r_at);
      mmu_rdata   = (i == r_at) ? rd : 32'h0;
      mmu_rresp   = (i == r_at) ? rr : 2'b00;
      settle;
      chk("rd_arvalid", mmu_arvalid, (i <= ar_at) ? 32'd1 : 32'd0);
      chk("rd_araddr_held", mmu_araddr, ea);
      chk("rd_no_grant", ifu_arready | lsu_arready | lsu_awready, 0);
      if (i == 0) begin
        chk("rd_arsize", mmu_arsize, esz);
        chk("rd_arlen", mmu_arlen, 0);
        chk("rd_arburst", mmu_arburst, 2'b01);
        chk("rd_arsatp", mmu_arsatp, s);
        chk("rd_no_aw", mmu_awvalid | mmu_wvalid, 0);
      end
      if (i == r_at) begin
        chk("rd_rready", mmu_rready, 1);
        observe_r();
      end
      tick;
    end
    mmu_arready = 1'b0;
    mmu_rvalid  = 1'b0;
    mmu_rlast   = 1'b0;
    settle;
    chk("rd_done_arvalid", mmu_arvalid, 0);
  endtask

  task automatic run_write(input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es,
                           input int aw_at, input int w_at, input int b_at, input logic [1:0] br);
    logic [31:0] s;
    s = satp;
    tick;
    satp = ~s;
    lsu_awvalid = 1'b0; lsu_awaddr = '1;
    lsu_wvalid  = 1'b0; lsu_wdata  = '0;
    for (int i = 0; i <= b_at; i++) begin
      mmu_awready = (i == aw_at);
      mmu_wready  = (i == w_at);
      mmu_bvalid  = (i == b_at);
      mmu_bresp   = br;
      settle;
      chk("wr_awvalid", mmu_awvalid, (i <= aw_at) ? 32'd1 : 32'd0);
      chk("wr_wvalid", mmu_wvalid, (i <= w_at) ? 32'd1 : 32'd0);
      if (i == 0) begin
        chk("wr_awaddr", mmu_awaddr, ea);
        chk("wr_wdata", mmu_wdata, ed);
        chk("wr_wstrb", mmu_wstrb, es);
        chk("wr_awsatp", mmu_awsatp, s);
        chk("wr_no_ar", mmu_arvalid, 0);
      end
      if (i == b_at) begin
        chk("wr_bready", mmu_bready, 1);
        observe_b();
      end else begin
        chk("wr_bvalid_idle", lsu_bvalid, 0);
      end
      tick;
    end
    mmu_awready = 1'b0;
    mmu_wready  = 1'b0;
    mmu_bvalid  = 1'b0;
    settle;
    chk("wr_done_bvalid", lsu_bvalid, 0);
  endtask

  initial begin
    logic [1:0] mseq[4];
    rst = 1'b1; satp = 32'h0;
    ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
    lsu_araddr = '0; lsu_arsize = 3'b010; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
    lsu_bready = 1'b1;
    mmu_arready = 1'b0; mmu_rdata = '0; mmu_rresp = 2'b00; mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
    mmu_awready = 1'b0; mmu_wready = 1'b0; mmu_bresp = 2'b00; mmu_bvalid = 1'b0;

    // Reset state
    tick; tick;
    rst = 1'b0;
    settle;
    chk("rst_arready", ifu_arready | lsu_arready | lsu_awready | lsu_wready, 0);
    chk("rst_mmu_valids", mmu_arvalid | mmu_awvalid | mmu_wvalid, 0);
    chk("rst_mmu_readies", mmu_rready | mmu_bready, 0);
    chk("rst_araddr", mmu_araddr, 0);
    chk("rst_satp", mmu_arsatp, 0);

    // IFU read alone, response three cycles after the address handshake
    tick;
    satp = 32'h8000_1234;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    settle;
    push(K_IFU, 32'h1234_5678, 2'b00);
    chk("t1_ifu_arready", ifu_arready, 1);
    chk("t1_lsu_arready", lsu_arready, 0);
    chk("t1_idle_no_arvalid", mmu_arvalid, 0);
    run_read(32'h8000_0000, 3'b010, 0, 3, 32'h1234_5678, 2'b00, 1'b1, 1'b0);
    chk("t1_arready_pulse", ifu_arready, 0);

    // IFU and LSU read together: LSU first (response with the ar handshake), then IFU
    tick;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0200; lsu_arsize = 3'b001;
    settle;
    push(K_LSU, 32'hA5A5_0001, 2'b10);
    push(K_IFU, 32'h0BAD_F00D, 2'b00);
    chk("t2_lsu_first", lsu_arready, 1);
    chk("t2_ifu_waits", ifu_arready, 0);
    run_read(32'h8000_0200, 3'b001, 0, 0, 32'hA5A5_0001, 2'b10, 1'b0, 1'b1);
    chk("t2_ifu_second", ifu_arready, 1);
    run_read(32'h8000_0100, 3'b010, 1, 2, 32'h0BAD_F00D, 2'b00, 1'b1, 1'b0);

    // LSU write, W handshake two cycles ahead of AW
    tick;
    satp = 32'h8000_0042;
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0010;
    lsu_wvalid = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    settle;
    push(K_WR, 32'h0, 2'b00);
    chk("t3_awready", lsu_awready, 1);
    chk("t3_wready", lsu_wready, 1);
    run_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2, 0, 3, 2'b00);
    chk("t3_no_regrant", lsu_awready, 0);

    // Write address without data: IFU read goes ahead, write waits for wvalid
    tick;
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0020;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0300;
    settle;
    push(K_IFU, 32'h1111_2222, 2'b00);
    chk("t4_ifu_granted", ifu_arready, 1);
    chk("t4_aw_alone_held", lsu_awready | lsu_wready, 0);
    run_read(32'h8000_0300, 3'b010, 0, 1, 32'h1111_2222, 2'b00, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("t4_write_waits", lsu_awready | mmu_awvalid, 0);
      tick;
    end
    lsu_wvalid = 1'b1; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'h3;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0500;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0600; lsu_arsize = 3'b000;
    settle;
    push(K_WR, 32'h0, 2'b00);
    push(K_LSU, 32'h3333_4444, 2'b00);
    push(K_IFU, 32'h5555_6666, 2'b00);
    chk("t4_write_beats_reads", {lsu_awready, lsu_wready, lsu_arready, ifu_arready}, 4'b1100);
    run_write(32'h8000_0020, 32'hCAFE_F00D, 4'h3, 1, 1, 2, 2'b00);
    chk("t4_lsu_after_write", lsu_arready, 1);
    run_read(32'h8000_0600, 3'b000, 0, 1, 32'h3333_4444, 2'b00, 1'b0, 1'b1);
    chk("t4_ifu_last", ifu_arready, 1);
    run_read(32'h8000_0500, 3'b010, 2, 2, 32'h5555_6666, 2'b00, 1'b1, 1'b0);

    // Reset in RD_LSU after the address handshake
    tick;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0700; lsu_arsize = 3'b010;
    settle;
    chk("t5_grant", lsu_arready, 1);
    tick;
    lsu_arvalid = 1'b0;
    mmu_arready = 1'b1;
    settle;
    chk("t5_arvalid", mmu_arvalid, 1);
    tick;
    mmu_arready = 1'b0;
    settle;
    chk("t5_ar_sent", mmu_arvalid, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mmu_rvalid = 1'b1; mmu_rlast = 1'b1; mmu_rdata = 32'h7777_7777;
    settle;
    chk("t5_arvalid_after_rst", mmu_arvalid, 0);
    chk("t5_rready_after_rst", mmu_rready, 0);
    chk("t5_rvalid_after_rst", lsu_rvalid, 0);
    chk("t5_araddr_cleared", mmu_araddr, 0);
    mmu_rvalid = 1'b0; mmu_rlast = 1'b0;
    tick;

    // Both masters requesting continuously for four reads
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      mseq[k] = (k % 2 == 0) ? K_IFU : K_LSU;
`else
      mseq[k] = K_LSU;
`endif
    end
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0800;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0900; lsu_arsize = 3'b010;
    for (int k = 0; k < 4; k++) push(mseq[k], 32'h600D_0000 + k, 2'b00);
    settle;
    for (int k = 0; k < 4; k++) begin
      chk("t6_ifu_grant", ifu_arready, (mseq[k] == K_IFU) ? 32'd1 : 32'd0);
      chk("t6_lsu_grant", lsu_arready, (mseq[k] == K_LSU) ? 32'd1 : 32'd0);
      run_read((mseq[k] == K_IFU) ? 32'h8000_0800 : 32'h8000_0900, 3'b010, k % 2, 1,
               32'h600D_0000 + k, 2'b00, 1'b0, 1'b0);
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
    settle;
    chk("t6_no_grant", ifu_arready | lsu_arready, 0);
    tick;
    chk("t6_stays_idle", mmu_arvalid, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
